// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and default widths for the FIR stream transmitter.
package fir_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fir_tx_state_e;
    localparam int FIR_DATA_W = 32;
    localparam int FIR_LEN_W  = 32;
endpackage

// File: rtl/fir_tx_fifo.sv
// fir_tx_fifo: small synchronous FIFO buffering core results ahead of the AXIS port.
module fir_tx_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             push_i,
    input  logic [pDATA_WIDTH-1:0]           din_i,
    output logic                             full_o,
    input  logic                             pop_i,
    output logic [pDATA_WIDTH-1:0]           dout_o,
    output logic                             empty_o,
    output logic [$clog2(FIFO_DEPTH):0]      count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [pDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;
    assign full_o  = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    always_comb begin
        wr_d  = wr_q + AW'(push_ok);
        rd_d  = rd_q + AW'(pop_ok);
        cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
    // Storage is not reset; only pointers and occupancy define valid contents.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fir_stream_out_tx.sv
// fir_stream_out_tx: AXI-Stream master that buffers FIR results and frames them
// into a run of in_data_length beats with tlast and a done pulse.
module fir_stream_out_tx
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH = FIR_DATA_W,
    parameter int LEN_WIDTH   = FIR_LEN_W,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   in_ap_start,
    input  logic [LEN_WIDTH-1:0]   in_data_length,
    input  logic                   in_core_y_valid,
    input  logic [pDATA_WIDTH-1:0] in_core_y,
    output logic                   out_core_y_ready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready,
    output logic                   out_ap_done,
    output logic                   out_tx_busy
);
    fir_tx_state_e state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, acc_cnt_q, acc_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [pDATA_WIDTH-1:0] fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic fifo_full, fifo_empty, push, pop;
    fir_tx_fifo #(.pDATA_WIDTH(pDATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (axis_clk),
        .rst_ni  (axis_rst_n),
        .push_i  (push),
        .din_i   (in_core_y),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
    // Ready depends only on registered state, so no combinational path from the core.
    assign out_core_y_ready = (state_q == RUN) && !fifo_full && (acc_cnt_q < len_q);
    assign sm_tvalid   = fifo_count != '0;
    assign sm_tdata    = fifo_empty ? '0 : fifo_dout;
    assign sm_tlast    = sm_tvalid && (tx_cnt_q == len_q - LEN_WIDTH'(1));
    assign push        = in_core_y_valid && out_core_y_ready;
    assign pop         = sm_tvalid && sm_tready;
    assign out_ap_done = state_q == DONE;
    assign out_tx_busy = state_q != IDLE;
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q + LEN_WIDTH'(push);
        tx_cnt_d  = tx_cnt_q + LEN_WIDTH'(pop);
        unique case (state_q)
            IDLE: if (in_ap_start) begin
                len_d     = in_data_length;
                acc_cnt_d = '0;
                tx_cnt_d  = '0;
                state_d   = (in_data_length == '0) ? DONE : RUN;
            end
            RUN:  state_d = (pop && sm_tlast) ? DONE : RUN;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            acc_cnt_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            acc_cnt_q <= acc_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
        end
    end
endmodule

// File: tb/tb_fir_stream_out_tx.sv
// tb_fir_stream_out_tx: randomized bench comparing the transmitter against a
// queue-based model of the run, plus literal checks on the delivered beats.
module tb_fir_stream_out_tx;
    logic        axis_clk = 0;
    logic        axis_rst_n = 0;
    logic        in_ap_start = 0;
    logic [31:0] in_data_length = 0;
    logic        in_core_y_valid = 0;
    logic [31:0] in_core_y = 0;
    logic        sm_tready = 0;
    logic        out_core_y_ready, sm_tvalid, sm_tlast, out_ap_done, out_tx_busy;
    logic [31:0] sm_tdata;

    fir_stream_out_tx dut (
        .axis_clk        (axis_clk),
        .axis_rst_n      (axis_rst_n),
        .in_ap_start     (in_ap_start),
        .in_data_length  (in_data_length),
        .in_core_y_valid (in_core_y_valid),
        .in_core_y       (in_core_y),
        .out_core_y_ready(out_core_y_ready),
        .sm_tvalid       (sm_tvalid),
        .sm_tdata        (sm_tdata),
        .sm_tlast        (sm_tlast),
        .sm_tready       (sm_tready),
        .out_ap_done     (out_ap_done),
        .out_tx_busy     (out_tx_busy)
    );

    always #5 axis_clk = ~axis_clk;

    int checks = 0;
    int errors = 0;
    logic [32:0] beats[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is "accept up to len samples, at most 2 waiting, emit them in order".
    bit          m_run, m_done;
    longint      m_len, m_acc, m_tx;
    logic [31:0] mq[$];

    function automatic bit e_ready();
        return m_run && mq.size() < 2 && m_acc < m_len;
    endfunction
    function automatic bit e_valid();
        return mq.size() > 0;
    endfunction
    function automatic logic [31:0] e_data();
        return e_valid() ? mq[0] : 32'h0;
    endfunction
    function automatic bit e_last();
        return e_valid() && m_tx == m_len - 1;
    endfunction

    always @(posedge axis_clk or negedge axis_rst_n) begin
        bit push, pop, lp;
        if (!axis_rst_n) begin
            m_run = 0; m_done = 0; m_len = 0; m_acc = 0; m_tx = 0;
            mq.delete();
        end else begin
            push = in_core_y_valid && e_ready();
            pop  = e_valid() && sm_tready;
            lp   = pop && e_last();
            if (m_done) m_done = 0;
            else if (!m_run) begin
                if (in_ap_start) begin
                    m_len = longint'(in_data_length);
                    m_acc = 0;
                    m_tx  = 0;
                    if (in_data_length == 0) m_done = 1;
                    else m_run = 1;
                end
            end else begin
                if (pop) begin void'(mq.pop_front()); m_tx++; end
                if (push) begin mq.push_back(in_core_y); m_acc++; end
                if (lp) begin m_run = 0; m_done = 1; end
            end
        end
    end

    always @(negedge axis_clk) begin
        chk("ready", out_core_y_ready, e_ready());
        chk("tvalid", sm_tvalid, e_valid());
        chk("tdata", sm_tdata, e_data());
        chk("tlast", sm_tlast, e_last());
        chk("done", out_ap_done, m_done);
        chk("busy", out_tx_busy, m_run || m_done);
    end

    task automatic run_case(input logic [31:0] len, input int n_vals, input logic [31:0] base,
                            input int stall, input bit rnd);
        int idx = 0;
        int cyc = 0;
        bit hs;
        bit seen = 0;
        beats.delete();
        @(negedge axis_clk);
        in_ap_start = 1;
        in_data_length = len;
        @(negedge axis_clk);
        in_ap_start = 0;
        while (!seen && cyc < 2000) begin
            if (out_ap_done) seen = 1;
            else begin
                in_core_y_valid = idx < n_vals;
                in_core_y = base + 32'(idx);
                sm_tready = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
                if (stall > 0 && cyc == stall) begin
                    chk("stall_ready", out_core_y_ready, 0);
                    chk("stall_valid", sm_tvalid, 1);
                    chk("stall_data", sm_tdata, base);
                end
                hs = in_core_y_valid && out_core_y_ready;
                if (sm_tvalid && sm_tready) beats.push_back({sm_tlast, sm_tdata});
                @(negedge axis_clk);
                if (hs) idx++;
                cyc++;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_beats(input string name, input int cnt, input logic [31:0] base);
        chk({name, "_count"}, beats.size(), cnt);
        for (int i = 0; i < beats.size() && i < cnt; i++)
            chk({name, "_beat"}, beats[i], {1'(i == cnt - 1), base + 32'(i)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        repeat (3) @(negedge axis_clk);
        chk("rst_busy", out_tx_busy, 0);
        chk("rst_tvalid", sm_tvalid, 0);
        #2 axis_rst_n = 1;

        run_case(4, 4, 32'h1, 0, 0);
        chk_beats("len4", 4, 32'h1);

        run_case(3, 3, 32'hA, 5, 0);
        chk_beats("stall", 3, 32'hA);

        run_case(0, 0, 32'h0, 0, 0);
        chk_beats("len0", 0, 32'h0);

        run_case(2, 4, 32'h5, 0, 0);
        chk("extra_ready", out_core_y_ready, 0);
        chk_beats("len2", 2, 32'h5);
        in_core_y_valid = 0;

        run_case(100, 100, 32'h0, 0, 1);
        chk_beats("rand100", 100, 32'h0);

        // Mid-run reset with two samples buffered behind a stalled sink.
        @(negedge axis_clk);
        in_ap_start = 1;
        in_data_length = 4;
        sm_tready = 0;
        @(negedge axis_clk);
        in_ap_start = 0;
        idx = 0;
        repeat (4) begin
            in_core_y_valid = 1;
            in_core_y = 32'h10 + 32'(idx);
            if (out_core_y_ready) idx++;
            @(negedge axis_clk);
        end
        chk("pre_rst_valid", sm_tvalid, 1);
        chk("pre_rst_data", sm_tdata, 32'h10);
        #3 axis_rst_n = 0;
        #1;
        chk("mid_rst_ready", out_core_y_ready, 0);
        chk("mid_rst_tvalid", sm_tvalid, 0);
        chk("mid_rst_tdata", sm_tdata, 0);
        chk("mid_rst_tlast", sm_tlast, 0);
        chk("mid_rst_done", out_ap_done, 0);
        chk("mid_rst_busy", out_tx_busy, 0);
        in_core_y_valid = 0;
        @(negedge axis_clk);
        #2 axis_rst_n = 1;

        run_case(1, 1, 32'h55, 0, 0);
        chk_beats("after_rst", 1, 32'h55);

        in_core_y_valid = 0;
        repeat (3) @(negedge axis_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
